// File: rtl/traffic_pkg.sv
// Shared lamp encodings and FSM state codes for the intersection controller.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  // Codes 5-7 are unused and recover to ST_HG.
  typedef enum logic [2:0] {
    ST_HG = 3'd0,
    ST_HY = 3'd1,
    ST_FG = 3'd2,
    ST_FY = 3'd3,
    ST_AR = 3'd4
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter; reports when the short and long intervals have elapsed.
module phase_timer #(
  parameter int SHORT_CYCLES = 5,
  parameter int LONG_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic short_done,
  output logic long_done
);

  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Holds at LONG_LAST so an idle highway green never wraps.
  always_ff @(posedge clk) begin
    if (reset || restart)
      r_cnt <= '0;
    else if (r_cnt < LONG_LAST)
      r_cnt <= r_cnt + 1'b1;
  end

  assign short_done = (r_cnt >= SHORT_LAST);
  assign long_done  = (r_cnt >= LONG_LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road Moore controller; farm green only on sensor demand.
// Optional all-red clearance between phases: define TRAFFIC_ALL_RED_EN.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int SHORT_CYCLES = 5,
  parameter int LONG_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  output logic [1:0] hl,
  output logic [1:0] fl,
  output logic [2:0] state_o,
  output logic       phase_start
);

  state_e r_state;
  state_e w_next;
  logic   w_restart;
  logic   w_short_done;
  logic   w_long_done;
  logic   r_phase_start;

`ifdef TRAFFIC_ALL_RED_EN
  // 1: current all-red phase leads to farm green, 0: to highway green.
  logic   r_to_farm;
  logic   w_to_farm_nxt;
`endif

  phase_timer #(
    .SHORT_CYCLES (SHORT_CYCLES),
    .LONG_CYCLES  (LONG_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .restart    (w_restart),
    .short_done (w_short_done),
    .long_done  (w_long_done)
  );

  always_comb begin
    w_next = r_state;
`ifdef TRAFFIC_ALL_RED_EN
    w_to_farm_nxt = r_to_farm;
`endif
    case (r_state)
      ST_HG: if (w_long_done && car) w_next = ST_HY;
      ST_HY: if (w_short_done) begin
`ifdef TRAFFIC_ALL_RED_EN
        w_next        = ST_AR;
        w_to_farm_nxt = 1'b1;
`else
        w_next = ST_FG;
`endif
      end
      ST_FG: if (!car || w_long_done) w_next = ST_FY;
      ST_FY: if (w_short_done) begin
`ifdef TRAFFIC_ALL_RED_EN
        w_next        = ST_AR;
        w_to_farm_nxt = 1'b0;
`else
        w_next = ST_HG;
`endif
      end
`ifdef TRAFFIC_ALL_RED_EN
      ST_AR: if (w_short_done) w_next = r_to_farm ? ST_FG : ST_HG;
`endif
      default: w_next = ST_HG;
    endcase
  end

  assign w_restart = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HG;
      r_phase_start <= 1'b1;
    end else begin
      r_state       <= w_next;
      r_phase_start <= w_restart;
    end
  end

`ifdef TRAFFIC_ALL_RED_EN
  always_ff @(posedge clk) begin
    if (reset)
      r_to_farm <= 1'b0;
    else
      r_to_farm <= w_to_farm_nxt;
  end
`endif

  // Lamps decode from the state register only, so they never glitch on car.
  always_comb begin
    hl = LAMP_RED;
    fl = LAMP_RED;
    case (r_state)
      ST_HG:   hl = LAMP_GREEN;
      ST_HY:   hl = LAMP_YELLOW;
      ST_FG:   fl = LAMP_GREEN;
      ST_FY:   fl = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign state_o     = r_state;
  assign phase_start = r_phase_start;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed phase tables plus randomized sensor traffic
// checked against a phase-age reference model; honours TRAFFIC_ALL_RED_EN.
module tb_traffic_light_ctrl;

  localparam int SC = 5;
  localparam int LC = 10;
`ifdef TRAFFIC_ALL_RED_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car = 1'b0;
  logic [1:0] hl, fl;
  logic [2:0] state_o;
  logic       phase_start;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.SHORT_CYCLES(SC), .LONG_CYCLES(LC)) dut (
    .clk         (clk),
    .reset       (reset),
    .car         (car),
    .hl          (hl),
    .fl          (fl),
    .state_o     (state_o),
    .phase_start (phase_start)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: which phase we are in and how many cycles it has lasted.
  int         m_state = 0;
  int         m_age   = 0;
  bit         m_first = 1'b1;
  bit         m_dir   = 1'b0;
  logic [2:0] prev_state = 3'bxxx;

  typedef struct {
    bit rst;
    bit car;
    int len;
    int st;
    int ps;  // 0 never, 1 first cycle of segment only, 2 every cycle
  } seg_t;
  seg_t segs[$];

  function automatic logic [3:0] lamps(input int st);
    case (st)
      0: return 4'b10_00;
      1: return 4'b01_00;
      2: return 4'b00_10;
      3: return 4'b00_01;
      default: return 4'b00_00;
    endcase
  endfunction

  function automatic seg_t mk(input bit r, input bit c, input int n, input int st, input int ps);
    seg_t s;
    s.rst = r; s.car = c; s.len = n; s.st = st; s.ps = ps;
    return s;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c);
    int nxt;
    if (r) begin
      m_state = 0; m_age = 0; m_first = 1'b1; m_dir = 1'b0;
      return;
    end
    nxt = m_state;
    case (m_state)
      0: if (m_age >= LC - 1 && c) nxt = 1;
      1: if (m_age >= SC - 1) begin nxt = AR_EN ? 4 : 2; m_dir = 1'b1; end
      2: if (!c || m_age >= LC - 1) nxt = 3;
      3: if (m_age >= SC - 1) begin nxt = AR_EN ? 4 : 0; m_dir = 1'b0; end
      4: if (m_age >= SC - 1) nxt = m_dir ? 2 : 0;
      default: nxt = 0;
    endcase
    if (nxt != m_state) begin
      m_state = nxt; m_age = 0; m_first = 1'b1;
    end else begin
      m_age++; m_first = 1'b0;
    end
  endtask

  task automatic cycle(input bit r, input bit c);
    reset = r;
    car   = c;
    @(posedge clk);
    model_step(r, c);
    @(negedge clk);
    chk("model", {state_o, hl, fl, phase_start}, {m_state[2:0], lamps(m_state), m_first});
    chk("safety", {7'd0, (hl != 2'b00) && (fl != 2'b00)}, 8'd0);
    chk("ps_on_change", {7'd0, (state_o !== prev_state) && !phase_start}, 8'd0);
    prev_state = state_o;
  endtask

  task automatic run_segs(input string name);
    foreach (segs[i]) begin
      for (int k = 0; k < segs[i].len; k++) begin
        bit exp_ps;
        cycle(segs[i].rst, segs[i].car);
        exp_ps = (segs[i].ps == 2) || (segs[i].ps == 1 && k == 0);
        chk(name, {state_o, hl, fl, phase_start},
            {segs[i].st[2:0], lamps(segs[i].st), exp_ps});
      end
    end
    segs.delete();
  endtask

  initial begin
    // Idle highway: reset 2 cycles, no car for 40 cycles.
    segs.push_back(mk(1, 0, 2, 0, 2));
    segs.push_back(mk(0, 0, 40, 0, 0));
    run_segs("idle");

    // Car held from cycle 0.
    segs.push_back(mk(1, 0, 1, 0, 1));
    segs.push_back(mk(0, 1, 9, 0, 0));
    segs.push_back(mk(0, 1, 5, 1, 1));
`ifdef TRAFFIC_ALL_RED_EN
    segs.push_back(mk(0, 1, 5, 4, 1));
    segs.push_back(mk(0, 1, 10, 2, 1));
    segs.push_back(mk(0, 1, 5, 3, 1));
    segs.push_back(mk(0, 1, 5, 4, 1));
    segs.push_back(mk(0, 1, 1, 0, 1));
`else
    segs.push_back(mk(0, 1, 10, 2, 1));
    segs.push_back(mk(0, 1, 5, 3, 1));
    segs.push_back(mk(0, 1, 1, 0, 1));
`endif
    run_segs("car_held");

    // Car leaves three cycles into farm green.
    segs.push_back(mk(1, 0, 1, 0, 1));
    segs.push_back(mk(0, 1, 9, 0, 0));
    segs.push_back(mk(0, 1, 5, 1, 1));
`ifdef TRAFFIC_ALL_RED_EN
    segs.push_back(mk(0, 1, 5, 4, 1));
    segs.push_back(mk(0, 1, 4, 2, 1));
    segs.push_back(mk(0, 0, 5, 3, 1));
    segs.push_back(mk(0, 0, 5, 4, 1));
`else
    segs.push_back(mk(0, 1, 4, 2, 1));
    segs.push_back(mk(0, 0, 5, 3, 1));
`endif
    segs.push_back(mk(0, 0, 1, 0, 1));
    segs.push_back(mk(0, 0, 5, 0, 0));
    run_segs("car_drop");

    // Reset in the middle of highway yellow, then a full minimum green again.
    segs.push_back(mk(1, 0, 1, 0, 1));
    segs.push_back(mk(0, 1, 9, 0, 0));
    segs.push_back(mk(0, 1, 3, 1, 1));
    segs.push_back(mk(1, 1, 1, 0, 1));
    segs.push_back(mk(0, 1, 9, 0, 0));
    segs.push_back(mk(0, 1, 1, 1, 1));
    run_segs("mid_reset");

    // Car arrives in exactly the cycle the minimum green completes.
    segs.push_back(mk(1, 0, 1, 0, 1));
    segs.push_back(mk(0, 0, 9, 0, 0));
    segs.push_back(mk(0, 1, 1, 1, 1));
    run_segs("late_car");

    // Random sensor traffic in held bursts, occasional reset.
    for (int n = 0; n < 300; n++) begin
      bit c;
      int len;
      c   = ($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++)
        cycle(($urandom_range(0, 199) == 0), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Moore FSM that sequences a two-road intersection: highway (main) and farm road (side).
- Farm road gets green only on demand from a car sensor.
- Phase durations come from an internal phase timer with short (yellow/clearance) and long (minimum green) intervals.
- Top-level controller; drives lamp outputs directly.

Parameters:
- SHORT_CYCLES, 5, yellow/clearance duration in clk cycles (must be >= 1).
- LONG_CYCLES, 10, highway minimum green and farm maximum green in clk cycles (must be >= SHORT_CYCLES).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- car  in  1  farm-road car sensor, level, synchronous to clk.
- hl  out  2  highway lamp: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN.
- fl  out  2  farm lamp, same encoding.
- state_o  out  3  current state code (debug/verification).
- phase_start  out  1  one-cycle pulse in the first cycle of every state.

Behaviour:
- States and codes: HG=0 (hl GREEN, fl RED), HY=1 (hl YELLOW, fl RED), FG=2 (hl RED, fl GREEN), FY=3 (hl RED, fl YELLOW), AR=4 (both RED; only with the optional feature).
- Outputs are decoded combinationally from the state register only, so they change in the same cycle as the state. No output depends on car combinationally.
- Phase counter `cnt`:
  - Width is $clog2(LONG_CYCLES+1).
  - It is 0 in the first cycle of a state and increments by 1 each following cycle.
  - It saturates at LONG_CYCLES-1.
- Derived flags:
  - short_done = (cnt >= SHORT_CYCLES-1).
  - long_done = (cnt >= LONG_CYCLES-1).
- Transitions are evaluated at the end of each cycle:
  - HG -> HY when long_done && car. HG holds indefinitely while car=0, with cnt saturated.
  - HY -> FG when short_done. HY therefore lasts exactly SHORT_CYCLES.
  - FG -> FY when !car || long_done. FG lasts at least 1 and at most LONG_CYCLES cycles.
  - FY -> HG when short_done. FY lasts exactly SHORT_CYCLES.
- On any transition: cnt <= 0 and phase_start = 1 in the new state's first cycle.
- Reset:
  - Next cycle: state=HG, cnt=0, hl=GREEN, fl=RED, state_o=0, phase_start=1.
  - Reset overrides all transitions, including mid-phase.
  - Reset held for several cycles keeps cnt=0 and phase_start=1.
- Simultaneous events:
  - car rising in the same cycle long_done first becomes true in HG transitions at the end of that cycle.
  - car falling in the FG cycle where long_done is true gives a single FG -> FY transition.
- Unused state codes (5-7) return to HG on the next edge.
- Safety invariant: hl and fl are never both non-RED in the same cycle.

Optional Feature:
- Macro: TRAFFIC_ALL_RED_EN.
- When defined:
  - HY -> AR and FY -> AR (instead of going directly to the next green).
  - AR lasts SHORT_CYCLES (exit on short_done), then goes to FG if entered from HY, or to HG if entered from FY.
  - A 1-bit register records which road the AR phase is heading to; it resets to 0 (highway).
  - AR outputs both RED, state_o=4.
- When undefined: AR and its direction register do not exist; transitions are as listed in Behaviour.

Decomposition:
- Package traffic_pkg holds:
  - lamp encodings LAMP_RED, LAMP_YELLOW, LAMP_GREEN (2-bit);
  - state enum typedef (3-bit) with the codes above.
- Sub-module phase_timer, parameterised by SHORT_CYCLES and LONG_CYCLES:
  - inputs: clk, reset, restart;
  - outputs: short_done, long_done;
  - contents: the saturating cnt;
  - behaviour: restart forces cnt to 0 on the next edge.
- The FSM drives restart high on every transition cycle.

Test Plan (SHORT_CYCLES=5, LONG_CYCLES=10, cycle 0 = first cycle after reset release):
- reset 2 cycles, car=0 for 40 cycles -> state_o=0, hl=10, fl=00 throughout; phase_start=1 only at cycle 0.
- car=1 from cycle 0 and held -> HG cycles 0-9, HY 10-14, FG 15-24, FY 25-29, HG at 30 (feature off).
- car=1 until FG entered at cycle 15, car=0 at cycle 18 -> FG cycles 15-18, FY 19-23, HG at 24.
- car=1, reset asserted at HY cycle 12 -> cycle 13: state_o=0, hl=10, fl=00, phase_start=1; HY re-entered no earlier than 10 cycles later.
- Feature on, car=1 -> HG 0-9, HY 10-14, AR 15-19 (hl=fl=00), FG 20-29, FY 30-34, AR 35-39, HG at 40.
- Every test: assertion that hl!=00 and fl!=00 never hold together, and that phase_start coincides with every state_o change.
